uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive buffer sitting directly downstream of the UART receiver; captures each byte on the receiver's one-cycle done strobe.
- Holds up to DEPTH bytes until the host/bus side pops them.
- First-word-fall-through read port; sticky overrun flag; almost-full level flag for flow control / interrupt.

Parameters:
DEPTH, 16, number of entries; power of 2, >= 4
DATA_W, 8, byte width
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL (1..DEPTH)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
wr_valid  input  1  one-cycle write strobe (receiver done)
wr_data  input  DATA_W  received byte
wr_err  input  1  framing error for this byte (receiver err)
rd_en  input  1  pop head entry this cycle
flush  input  1  synchronous clear of contents
overrun_clr  input  1  clears sticky overrun
rd_data  output  DATA_W  head entry data, valid while !empty
rd_err  output  1  head entry error tag, valid while !empty
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_full  output  1  count >= AF_LEVEL
count  output  $clog2(DEPTH+1)  current occupancy
overrun  output  1  sticky: byte dropped because FIFO full

Behaviour:
- Reset (clk edge with reset=1): wr_ptr=rd_ptr=0, count=0, overrun=0; empty=1, full=0, almost_full=0, rd_data=0, rd_err=0. Memory contents need not be cleared.
- Storage: DEPTH entries of {err, data}; pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
- Write: wr_valid && accept -> entry written at wr_ptr, wr_ptr++, visible on rd_data next cycle if the FIFO was empty (write-to-read latency 1 cycle).
- Read: FWFT; rd_data/rd_err combinationally reflect mem[rd_ptr]. rd_en && !empty -> rd_ptr++ at edge. rd_en while empty is ignored, with no state change.
- Count rules per edge:
  - push only: +1.
  - pop only: -1.
  - push + pop with FIFO non-empty: both take effect, count unchanged. This applies when full: pop frees the slot, the push is accepted, and overrun is not set.
  - push + pop when empty: push accepted, pop ignored, count=1.
- Overrun: wr_valid && full && !rd_en -> byte dropped, pointers unchanged, overrun<=1. overrun holds until overrun_clr. If overrun_clr and a new overrun occur in the same cycle, set wins.
- flush: pointers and count <= 0 at the edge, overrun unaffected. wr_valid in the same cycle is discarded and rd_en is ignored. reset has priority over flush.
- Reset mid-stream: all queued bytes are lost; a write in the reset cycle is discarded.
- Flags are derived from registered count; no combinational path from wr_valid/rd_en to full/empty.

Optional Feature:
- Macro UART_RX_ERR_TAG_EN.
- Defined: entries are DATA_W+1 bits; bytes with wr_err=1 are stored and their tag is presented on rd_err.
- Undefined: entries are DATA_W bits; wr_valid with wr_err=1 is dropped silently (no count change, no overrun); rd_err tied 0.

Decomposition:
- definitions_pkg additions: typedef struct packed {logic err; logic [7:0] data;} rx_entry_t; localparam RX_FIFO_DEPTH_DEFAULT=16.
- One sub-module: uart_rx_fifo_mem, a simple dual-port register array (sync write, async read), parameterised by width and depth.
- Pointer/count/flag logic stays in uart_rx_fifo.

Test Plan:
- Reset then push 0xA5, 0x5A -> one cycle after first push: empty=0, rd_data=0xA5. After two pops: rd_data sequence 0xA5, 0x5A, then empty=1, count=0.
- Push 16 bytes 0x00..0x0F -> full=1, count=16, almost_full from the 12th push. Push 0xFF with no pop -> overrun=1, count stays 16. Drain returns 0x00..0x0F; 0xFF is absent.
- Full FIFO, simultaneous wr_valid(0x77)+rd_en -> count stays 16, overrun=0. The last entry popped after the drain is 0x77 (wrap-around checked).
- Empty FIFO, simultaneous wr_valid(0x12)+rd_en -> count=1, rd_data=0x12.
- Push 0x34 with wr_err=1: with UART_RX_ERR_TAG_EN, rd_err=1 at head; without it, empty stays 1.
- Overrun set, then overrun_clr asserted in the same cycle as another full-FIFO push -> overrun stays 1. Next overrun_clr alone -> 0. flush with 5 queued bytes -> empty=1 next cycle, overrun unchanged.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and defaults for the UART receive FIFO.
package uart_rx_fifo_pkg;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } rx_entry_t;

  localparam int unsigned RX_FIFO_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module uart_rx_fifo_mem #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with sticky overrun and almost-full flag.
// Optional macro UART_RX_ERR_TAG_EN stores the framing-error tag with each byte.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH    = RX_FIFO_DEPTH_DEFAULT,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned AF_LEVEL = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_err,
  input  logic                       rd_en,
  input  logic                       flush,
  input  logic                       overrun_clr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_err,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overrun
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
`ifdef UART_RX_ERR_TAG_EN
  localparam int unsigned EntryW = DATA_W + 1;
`else
  localparam int unsigned EntryW = DATA_W;
`endif

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              byte_ok, push, pop, drop;
  logic [EntryW-1:0] wr_entry, rd_entry;

`ifdef UART_RX_ERR_TAG_EN
  assign byte_ok  = 1'b1;
  assign wr_entry = {wr_err, wr_data};
  assign rd_err   = empty ? 1'b0 : rd_entry[DATA_W];
`else
  // Without tag storage, errored bytes are discarded at the door.
  assign byte_ok  = ~wr_err;
  assign wr_entry = wr_data;
  assign rd_err   = 1'b0;
`endif

  assign empty       = (count_q == '0);
  assign full        = (count_q == CntW'(DEPTH));
  assign almost_full = (count_q >= CntW'(AF_LEVEL));
  assign count       = count_q;
  assign overrun     = overrun_q;
  assign rd_data     = empty ? '0 : rd_entry[DATA_W-1:0];

  always_comb begin
    // A pop on a full FIFO frees the slot the concurrent push needs.
    push = wr_valid & byte_ok & (~full | rd_en) & ~flush;
    pop  = rd_en & ~empty & ~flush;
    drop = wr_valid & byte_ok & full & ~rd_en & ~flush;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = drop ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  uart_rx_fifo_mem #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push & ~reset),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_uart_rx_fifo;

  localparam int unsigned Depth = 16;
  localparam int unsigned AfLvl = 12;
`ifdef UART_RX_ERR_TAG_EN
  localparam bit TagEn = 1'b1;
`else
  localparam bit TagEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_err = 1'b0;
  logic       rd_en = 1'b0;
  logic       flush = 1'b0;
  logic       overrun_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_err, empty, full, almost_full, overrun;
  logic [4:0] count;

  int n_checks = 0;
  int n_fail = 0;

  bit [8:0] mq[$];
  bit       m_ovr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH    (Depth),
    .DATA_W   (8),
    .AF_LEVEL (AfLvl)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_err      (wr_err),
    .rd_en       (rd_en),
    .flush       (flush),
    .overrun_clr (overrun_clr),
    .rd_data     (rd_data),
    .rd_err      (rd_err),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .overrun     (overrun)
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {err, data} following the FIFO rules.
  task automatic model(input bit rs, input bit wv, input bit [7:0] wd, input bit we,
                       input bit re, input bit fl, input bit oc);
    bit ok, mfull, mempty, set;
    if (rs) begin
      mq.delete();
      m_ovr = 1'b0;
      return;
    end
    ok = wv && (TagEn || !we);
    set = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      mfull  = (mq.size() == Depth);
      mempty = (mq.size() == 0);
      if (re && !mempty) void'(mq.pop_front());
      if (ok && (!mfull || re)) mq.push_back({we & TagEn, wd});
      set = ok && mfull && !re;
    end
    m_ovr = set ? 1'b1 : (oc ? 1'b0 : m_ovr);
  endtask

  task automatic check_all();
    int unsigned sz = mq.size();
    check("count", count, sz);
    check("empty", empty, sz == 0);
    check("full", full, sz == Depth);
    check("almost_full", almost_full, sz >= AfLvl);
    check("overrun", overrun, m_ovr);
    check("rd_data", rd_data, (sz != 0) ? mq[0][7:0] : 0);
    check("rd_err", rd_err, (sz != 0) ? mq[0][8] : 0);
  endtask

  task automatic step(input bit rs, input bit wv, input bit [7:0] wd, input bit we,
                      input bit re, input bit fl, input bit oc);
    reset = rs; wr_valid = wv; wr_data = wd; wr_err = we;
    rd_en = re; flush = fl; overrun_clr = oc;
    @(posedge clk);
    model(rs, wv, wd, we, re, fl, oc);
    #1;
    reset = 1'b0; wr_valid = 1'b0; wr_err = 1'b0; rd_en = 1'b0;
    flush = 1'b0; overrun_clr = 1'b0;
    check_all();
  endtask

  task automatic push(input bit [7:0] d);
    step(0, 1, d, 0, 0, 0, 0);
  endtask

  task automatic pop();
    step(0, 0, 8'h00, 0, 1, 0, 0);
  endtask

  initial begin
    // Reset and basic FWFT latency.
    step(1, 0, 8'h00, 0, 0, 0, 0);
    check("rst_empty", empty, 1);
    check("rst_rd_data", rd_data, 0);
    push(8'hA5);
    check("first_head", rd_data, 8'hA5);
    push(8'h5A);
    pop();
    check("second_head", rd_data, 8'h5A);
    pop();
    check("drained_empty", empty, 1);

    // Fill, almost_full threshold, overrun.
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      check("af_edge", almost_full, (i >= 11));
    end
    check("full_count", count, 16);
    push(8'hFF);
    check("ovr_set", overrun, 1);
    check("ovr_count", count, 16);
    step(0, 1, 8'hEE, 0, 0, 0, 1);
    check("ovr_set_wins", overrun, 1);
    step(0, 0, 8'h00, 0, 0, 0, 1);
    check("ovr_clr", overrun, 0);

    // Push+pop on full: wrap-around, no overrun.
    step(0, 1, 8'h77, 0, 1, 0, 0);
    check("full_pp_count", count, 16);
    check("full_pp_ovr", overrun, 0);
    for (int i = 1; i < 16; i++) begin
      check("drain_order", rd_data, i);
      pop();
    end
    check("wrapped_last", rd_data, 8'h77);
    pop();

    // Push+pop on empty.
    step(0, 1, 8'h12, 0, 1, 0, 0);
    check("empty_pp_count", count, 1);
    check("empty_pp_data", rd_data, 8'h12);
    pop();

    // Errored byte.
    step(0, 1, 8'h34, 1, 0, 0, 0);
    if (TagEn) check("err_tag", rd_err, 1);
    else       check("err_drop", empty, 1);
    if (!empty) pop();

    // Flush with 5 queued bytes while overrun is set.
    for (int i = 0; i < 17; i++) push(8'(8'h40 + i));
    for (int i = 0; i < 11; i++) pop();
    check("pre_flush_count", count, 5);
    step(0, 1, 8'h99, 0, 1, 1, 0);
    check("flush_empty", empty, 1);
    check("flush_ovr_kept", overrun, 1);

    // Random traffic with phases biased toward filling or draining.
    for (int i = 0; i < 3000; i++) begin
      int unsigned rd_pct;
      rd_pct = ((i / 200) % 2 == 0) ? 25 : 70;
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 99) < 60,
           8'($urandom),
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 99) < rd_pct,
           $urandom_range(0, 127) == 0,
           $urandom_range(0, 15) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
